// File: rtl/vga_scanout.sv
// VGA 640x480@60 scan-out of the 240x160 BGR555 framebuffer, scaled 2x2 and centred.
// Framebuffer reads are issued from the counter state; sync/blanking are delayed to meet the data.
module vga_scanout #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int X_OFS    = 80,
    parameter int Y_OFS    = 80,
    parameter int RD_LAT   = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [14:0] data,
    output logic [16:0] addr,
    output logic [3:0]  VGA_R,
    output logic [3:0]  VGA_G,
    output logic [3:0]  VGA_B,
    output logic        VGA_HS,
    output logic        VGA_VS,
    output logic        frame_start
);

    localparam int SRC_W   = 240;
    localparam int SRC_H   = 160;
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0]  H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0]  HS_LO  = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0]  HS_HI  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0]  VS_LO  = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]  VS_HI  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [9:0]  X_LO   = 10'(X_OFS);
    localparam logic [9:0]  X_HI   = 10'(X_OFS + 2 * SRC_W - 1);
    localparam logic [9:0]  Y_LO   = 10'(Y_OFS);
    localparam logic [9:0]  Y_HI   = 10'(Y_OFS + 2 * SRC_H - 1);
    localparam logic [16:0] LB_STEP = 17'(SRC_W);

    // Flag vector layout: {win, hs_n, vs_n, fs}
    localparam logic [3:0] FLAGS_IDLE = 4'b0110;

    logic [9:0]  h_reg;
    logic [9:0]  v_reg;
    logic [16:0] line_base_reg;
    logic [3:0]  pipe_reg [RD_LAT];

    logic        win_h;
    logic        win_v;
    logic        odd_line;
    logic [9:0]  h_rel;
    logic [8:0]  sx;
    logic [3:0]  flags0;
    logic [3:0]  flags_dly;
    logic        data_lsb_unused;

    assign win_h    = (h_reg >= X_LO) && (h_reg <= X_HI);
    assign win_v    = (v_reg >= Y_LO) && (v_reg <= Y_HI);
    assign h_rel    = h_reg - X_LO;
    assign sx       = h_rel[9:1];
    // Parity of (v - Y_OFS) is the xor of the operand LSBs.
    assign odd_line = v_reg[0] ^ Y_LO[0];

    assign addr = (win_h && win_v) ? (line_base_reg + {8'd0, sx}) : 17'd0;

    assign flags0 = {win_h && win_v,
                     ~((h_reg >= HS_LO) && (h_reg <= HS_HI)),
                     ~((v_reg >= VS_LO) && (v_reg <= VS_HI)),
                     (h_reg == 10'd0) && (v_reg == 10'd0)};

    assign flags_dly       = pipe_reg[RD_LAT-1];
    assign data_lsb_unused = ^{data[0], data[5], data[10], h_rel[0]};

    always_ff @(posedge clock) begin
        if (reset) begin
            h_reg         <= '0;
            v_reg         <= '0;
            line_base_reg <= '0;
        end else if (h_reg == H_LAST) begin
            h_reg <= '0;
            v_reg <= (v_reg == V_LAST) ? 10'd0 : v_reg + 10'd1;
            // Frame wrap clears the base before any odd-line advance.
            if (v_reg == V_LAST)
                line_base_reg <= '0;
            else if (win_v && odd_line)
                line_base_reg <= line_base_reg + LB_STEP;
        end else begin
            h_reg <= h_reg + 10'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < RD_LAT; i++)
                pipe_reg[i] <= FLAGS_IDLE;
        end else begin
            pipe_reg[0] <= flags0;
            for (int i = 1; i < RD_LAT; i++)
                pipe_reg[i] <= pipe_reg[i-1];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            VGA_R       <= '0;
            VGA_G       <= '0;
            VGA_B       <= '0;
            VGA_HS      <= 1'b1;
            VGA_VS      <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            VGA_HS      <= flags_dly[2];
            VGA_VS      <= flags_dly[1];
            frame_start <= flags_dly[0];
            if (flags_dly[3]) begin
                VGA_R <= data[4:1];
                VGA_G <= data[9:6];
                VGA_B <= data[14:11];
            end else begin
                VGA_R <= '0;
                VGA_G <= '0;
                VGA_B <= '0;
            end
        end
    end

endmodule
